cmp2_seq_ctrl: RTL

Sequencing controller that compares two WIDTH-bit unsigned operands using one shared 2-bit magnitude comparator slice (outputs Eq/Gt/Lt). It drives the slice MSB-first, one 2-bit digit per cycle, stops early on the first unequal digit, and reports a one-hot result with a start/done handshake. It sits between the operand source and a single comparator slice instance, so wide comparisons reuse one small gate-level comparator.

---
 rtl/cmp2_seq_ctrl_if.sv | 30 +++
 rtl/cmp2_seq_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cmp2_seq_ctrl_if.sv
// Operand-source / comparator-slice bus of the digit-serial compare controller.
// The controller uses the slave modport; the environment drives through master.
interface cmp2_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       cmp_a;
    logic [1:0]       cmp_b;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             err;

    modport slave (
        input  start, a_in, b_in, cmp_eq, cmp_gt, cmp_lt,
        output cmp_a, cmp_b, busy, done, eq, gt, lt, err
    );

    modport master (
        output start, a_in, b_in, cmp_eq, cmp_gt, cmp_lt,
        input  cmp_a, cmp_b, busy, done, eq, gt, lt, err
    );
endinterface

// File: rtl/cmp2_seq_ctrl.sv
// MSB-first digit-serial magnitude compare driving one shared 2-bit comparator
// slice; stops on the first unequal digit and reports a one-hot result.
module cmp2_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp2_seq_ctrl_if.slave       bus
);
    localparam int unsigned K     = WIDTH / 2;
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         cmp_a_q, cmp_a_d;
    logic [1:0]         cmp_b_q, cmp_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               err_q, err_d;
    logic [2:0]         resp_c;

    assign resp_c = {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt};

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
            S_RUN: begin
                if (resp_c == 3'b100 && idx_q != '0) state_d = S_RUN;
                else                                 state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; digit outputs are pre-selected for the
    // coming cycle so the slice sees a registered digit while in RUN.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        idx_d = idx_q;
        eq_d  = eq_q;
        gt_d  = gt_q;
        lt_d  = lt_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a_in;
                    b_d   = bus.b_in;
                    idx_d = IDX_W'(K - 1);
                    eq_d  = 1'b0;
                    gt_d  = 1'b0;
                    lt_d  = 1'b0;
                    err_d = 1'b0;
                end
            end
            S_RUN: begin
                case (resp_c)
                    3'b010: gt_d = 1'b1;
                    3'b001: lt_d = 1'b1;
                    3'b100: begin
                        if (idx_q == '0) eq_d = 1'b1;
                        else             idx_d = idx_q - IDX_W'(1);
                    end
                    default: err_d = 1'b1;
                endcase
            end
            default: ;
        endcase
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        cmp_a_d = (state_d == S_RUN) ? a_d[{idx_d, 1'b0} +: 2] : 2'b00;
        cmp_b_d = (state_d == S_RUN) ? b_d[{idx_d, 1'b0} +: 2] : 2'b00;
    end

    assign bus.cmp_a = cmp_a_q;
    assign bus.cmp_b = cmp_b_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.eq    = eq_q;
    assign bus.gt    = gt_q;
    assign bus.lt    = lt_q;
    assign bus.err   = err_q;
endmodule
